// File: rtl/alu_seq_param.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_param
//  Purpose  : W-bit handshaked sequential ALU (add/sub/inc/dec/cmp, bounded
//             up/down count, shift-add multiply) with registered results.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_seq_param #(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     in1,
    input  logic [W-1:0]     in2,
    input  logic [2:0]       s,
    input  logic             ld,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   out,
    output logic             cout,
    output logic             zero
);

    localparam int CW = $clog2(W);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_INC  = 3'b010;
    localparam logic [2:0] OP_DEC  = 3'b011;
    localparam logic [2:0] OP_UCNT = 3'b101;
    localparam logic [2:0] OP_DCNT = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;

    localparam logic [W-1:0]  ONE_W     = W'(1);
    localparam logic [CW-1:0] ITER_ONE  = CW'(1);
    localparam logic [CW-1:0] ITER_LAST = CW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CNT  = 2'd2,
        MUL  = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [W-1:0]    a, a_n;
    logic [W-1:0]    b, b_n;
    logic [2:0]      op, op_n;
    logic [2*W-1:0]  out_n;
    logic            cout_n;
    logic            zero_n;
    logic            done_n;
    logic [2*W-1:0]  acc, acc_n;
    logic [2*W-1:0]  mcand, mcand_n;
    logic [W-1:0]    mplier, mplier_n;
    logic [CW-1:0]   iter, iter_n;
    logic            first, first_n;

    logic [W:0]      add_sum;
    logic [W-1:0]    sub_dif;
    logic [W-1:0]    cnt_cur;
    logic [W-1:0]    cnt_nxt;
    logic            cnt_wrap;
    logic            reached;
    logic [2*W-1:0]  mul_sum;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            a      <= '0;
            b      <= '0;
            op     <= '0;
            out    <= '0;
            cout   <= 1'b0;
            zero   <= 1'b0;
            done   <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            iter   <= '0;
            first  <= 1'b0;
        end else begin
            state  <= state_n;
            a      <= a_n;
            b      <= b_n;
            op     <= op_n;
            out    <= out_n;
            cout   <= cout_n;
            zero   <= zero_n;
            done   <= done_n;
            acc    <= acc_n;
            mcand  <= mcand_n;
            mplier <= mplier_n;
            iter   <= iter_n;
            first  <= first_n;
        end
    end

    always_comb begin
        state_n  = state;
        a_n      = a;
        b_n      = b;
        op_n     = op;
        out_n    = out;
        cout_n   = cout;
        zero_n   = zero;
        done_n   = 1'b0;
        acc_n    = acc;
        mcand_n  = mcand;
        mplier_n = mplier;
        iter_n   = iter;
        first_n  = first;
        reached  = 1'b0;

        add_sum  = {1'b0, a} + {1'b0, b};
        sub_dif  = a - b;
        cnt_cur  = out[W-1:0];
        cnt_nxt  = (op == OP_UCNT) ? (cnt_cur + ONE_W) : (cnt_cur - ONE_W);
        cnt_wrap = (op == OP_UCNT) ? (&cnt_cur) : (~|cnt_cur);
        mul_sum  = acc + (mplier[0] ? mcand : '0);

        case (state)
            IDLE: begin
                if (ld) begin
                    a_n      = in1;
                    b_n      = in2;
                    op_n     = s;
                    acc_n    = '0;
                    mcand_n  = {{W{1'b0}}, in1};
                    mplier_n = in2;
                    iter_n   = '0;
                    first_n  = 1'b1;
                    case (s)
                        OP_UCNT, OP_DCNT: state_n = CNT;
                        OP_MUL:           state_n = MUL;
                        default:          state_n = EXEC;
                    endcase
                end
            end

            EXEC: begin
                out_n  = '0;
                cout_n = 1'b0;
                case (op)
                    // Carry lands both in cout and in out[W].
                    OP_ADD: begin
                        out_n[W:0] = add_sum;
                        cout_n     = add_sum[W];
                    end
                    OP_SUB: begin
                        out_n[W-1:0] = sub_dif;
                        cout_n       = (a < b);
                    end
                    OP_INC: begin
                        out_n[W-1:0] = a + ONE_W;
                        cout_n       = &a;
                    end
                    OP_DEC: begin
                        out_n[W-1:0] = a - ONE_W;
                        cout_n       = ~|a;
                    end
                    default: begin
                        out_n[2:0] = {(a < b), (a == b), (a > b)};
                    end
                endcase
                done_n  = 1'b1;
                state_n = IDLE;
            end

            CNT: begin
                // First cycle loads the start value; wrap flag is sticky afterwards.
                if (first) begin
                    out_n   = {{W{1'b0}}, a};
                    cout_n  = 1'b0;
                    first_n = 1'b0;
                    reached = (a == b);
                end else begin
                    out_n   = {{W{1'b0}}, cnt_nxt};
                    cout_n  = cout | cnt_wrap;
                    reached = (cnt_nxt == b);
                end
                if (reached) begin
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end

            MUL: begin
                acc_n    = mul_sum;
                mcand_n  = mcand << 1;
                mplier_n = mplier >> 1;
                iter_n   = iter + ITER_ONE;
                if (iter == ITER_LAST) begin
                    out_n   = mul_sum;
                    cout_n  = |mul_sum[2*W-1:W];
                    done_n  = 1'b1;
                    state_n = IDLE;
                end
            end

            default: state_n = IDLE;
        endcase

        if (done_n) begin
            zero_n = ~|out_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_seq_param
//  Purpose  : Directed-table and reference-model bench for alu_seq_param at
//             W=4 and W=8.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_seq_param;

    logic        clk = 1'b0;
    logic        rst;

    logic [3:0]  in1_4, in2_4;
    logic [2:0]  s_4;
    logic        ld_4;
    logic        busy_4, done_4, cout_4, zero_4;
    logic [7:0]  out_4;

    logic [7:0]  in1_8, in2_8;
    logic [2:0]  s_8;
    logic        ld_8;
    logic        busy_8, done_8, cout_8, zero_8;
    logic [15:0] out_8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_seq_param #(.W(4)) dut4 (
        .clk(clk), .rst(rst), .in1(in1_4), .in2(in2_4), .s(s_4), .ld(ld_4),
        .busy(busy_4), .done(done_4), .out(out_4), .cout(cout_4), .zero(zero_4)
    );

    alu_seq_param #(.W(8)) dut8 (
        .clk(clk), .rst(rst), .in1(in1_8), .in2(in2_8), .s(s_8), .ld(ld_8),
        .busy(busy_8), .done(done_8), .out(out_8), .cout(cout_8), .zero(zero_8)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [7:0] out;
        logic       cout;
        logic       zero;
        int         lat;
    } vec_t;

    vec_t tbl[23];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run4(input vec_t v, input int idx);
        int lat;
        bit seen;
        @(negedge clk);
        in1_4 = v.a; in2_4 = v.b; s_4 = v.op; ld_4 = 1'b1;
        @(posedge clk); #1;
        ld_4 = 1'b0; in1_4 = ~v.a; in2_4 = ~v.b; s_4 = ~v.op;
        check($sformatf("v%0d busy_after_capture", idx), busy_4, 1);
        lat = 0; seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            seen = done_4;
        end
        check($sformatf("v%0d done_seen", idx), seen, 1);
        check($sformatf("v%0d latency", idx), lat, v.lat);
        check($sformatf("v%0d out", idx), out_4, v.out);
        check($sformatf("v%0d cout", idx), cout_4, v.cout);
        check($sformatf("v%0d zero", idx), zero_4, v.zero);
        check($sformatf("v%0d busy_at_done", idx), busy_4, 0);
        @(posedge clk); #1;
        check($sformatf("v%0d done_single", idx), done_4, 0);
    endtask

    task automatic model8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                          output logic [15:0] o, output logic c, output int lat);
        logic [8:0] t;
        logic [7:0] d;
        o = '0; c = 1'b0; lat = 1;
        case (op)
            3'd0: begin t = {1'b0, a} + {1'b0, b}; o = {7'b0, t}; c = t[8]; end
            3'd1: begin d = a - b; o = {8'b0, d}; c = (a < b); end
            3'd2: begin d = a + 8'd1; o = {8'b0, d}; c = (a == 8'hFF); end
            3'd3: begin d = a - 8'd1; o = {8'b0, d}; c = (a == 8'h00); end
            3'd4: begin o = {13'b0, (a < b), (a == b), (a > b)}; end
            3'd5: begin d = b - a; lat = int'(d) + 1; o = {8'b0, b}; c = (b < a); end
            3'd6: begin d = a - b; lat = int'(d) + 1; o = {8'b0, b}; c = (b > a); end
            default: begin o = 16'(a) * 16'(b); c = (o[15:8] != 8'h00); lat = 8; end
        endcase
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                        input bit noise, input int idx);
        logic [15:0] eo;
        logic        ec;
        int          elat, lat;
        bit          seen;
        model8(a, b, op, eo, ec, elat);
        @(negedge clk);
        in1_8 = a; in2_8 = b; s_8 = op; ld_8 = 1'b1;
        @(posedge clk); #1;
        ld_8 = 1'b0;
        lat = 0; seen = 1'b0;
        while (!seen && lat < 300) begin
            // Garbage requests while busy must be dropped.
            @(negedge clk);
            if (noise) begin
                ld_8 = 1'b1; in1_8 = 8'($urandom); in2_8 = 8'($urandom); s_8 = 3'($urandom);
            end
            @(posedge clk); #1;
            ld_8 = 1'b0;
            lat++;
            seen = done_8;
        end
        check($sformatf("r%0d done_seen op%0d", idx, op), seen, 1);
        check($sformatf("r%0d latency op%0d", idx, op), lat, elat);
        check($sformatf("r%0d out op%0d a%0h b%0h", idx, op, a, b), out_8, eo);
        check($sformatf("r%0d cout op%0d", idx, op), cout_8, ec);
        check($sformatf("r%0d zero op%0d", idx, op), zero_8, (eo == 16'h0));
        @(posedge clk); #1;
        check($sformatf("r%0d done_single", idx), done_8, 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] exp_cnt[5];
        logic [7:0] ra, rb;
        logic [2:0] rop;

        tbl[0]  = '{4'd9,  4'd8,  3'd0, 8'h11, 1'b1, 1'b0, 1};
        tbl[1]  = '{4'd0,  4'd0,  3'd0, 8'h00, 1'b0, 1'b1, 1};
        tbl[2]  = '{4'd7,  4'd8,  3'd0, 8'h0F, 1'b0, 1'b0, 1};
        tbl[3]  = '{4'd3,  4'd5,  3'd1, 8'h0E, 1'b1, 1'b0, 1};
        tbl[4]  = '{4'd9,  4'd9,  3'd1, 8'h00, 1'b0, 1'b1, 1};
        tbl[5]  = '{4'd15, 4'd0,  3'd1, 8'h0F, 1'b0, 1'b0, 1};
        tbl[6]  = '{4'd15, 4'd0,  3'd2, 8'h00, 1'b1, 1'b1, 1};
        tbl[7]  = '{4'd6,  4'd0,  3'd2, 8'h07, 1'b0, 1'b0, 1};
        tbl[8]  = '{4'd0,  4'd0,  3'd3, 8'h0F, 1'b1, 1'b0, 1};
        tbl[9]  = '{4'd1,  4'd0,  3'd3, 8'h00, 1'b0, 1'b1, 1};
        tbl[10] = '{4'd5,  4'd5,  3'd4, 8'h02, 1'b0, 1'b0, 1};
        tbl[11] = '{4'd3,  4'd9,  3'd4, 8'h04, 1'b0, 1'b0, 1};
        tbl[12] = '{4'd12, 4'd2,  3'd4, 8'h01, 1'b0, 1'b0, 1};
        tbl[13] = '{4'd15, 4'd15, 3'd7, 8'hE1, 1'b1, 1'b0, 4};
        tbl[14] = '{4'd3,  4'd5,  3'd7, 8'h0F, 1'b0, 1'b0, 4};
        tbl[15] = '{4'd0,  4'd9,  3'd7, 8'h00, 1'b0, 1'b1, 4};
        tbl[16] = '{4'd4,  4'd4,  3'd7, 8'h10, 1'b1, 1'b0, 4};
        tbl[17] = '{4'd14, 4'd2,  3'd5, 8'h02, 1'b1, 1'b0, 5};
        tbl[18] = '{4'd3,  4'd3,  3'd6, 8'h03, 1'b0, 1'b0, 1};
        tbl[19] = '{4'd5,  4'd8,  3'd5, 8'h08, 1'b0, 1'b0, 4};
        tbl[20] = '{4'd2,  4'd14, 3'd6, 8'h0E, 1'b1, 1'b0, 5};
        tbl[21] = '{4'd1,  4'd0,  3'd6, 8'h00, 1'b0, 1'b1, 2};
        tbl[22] = '{4'd15, 4'd15, 3'd5, 8'h0F, 1'b0, 1'b0, 1};

        rst = 1'b0;
        in1_4 = '0; in2_4 = '0; s_4 = '0; ld_4 = 1'b0;
        in1_8 = '0; in2_8 = '0; s_8 = '0; ld_8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst4 busy", busy_4, 0);
        check("rst4 done", done_4, 0);
        check("rst4 out",  out_4,  0);
        check("rst4 cout", cout_4, 0);
        check("rst4 zero", zero_4, 0);
        check("rst8 busy", busy_8, 0);
        check("rst8 out",  out_8,  0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 23; i++) begin
            run4(tbl[i], i);
        end

        // mul 15*15 with a stray ld at edge 2; out must hold the previous result.
        @(negedge clk);
        in1_4 = 4'd15; in2_4 = 4'd15; s_4 = 3'd7; ld_4 = 1'b1;
        @(posedge clk); #1;
        ld_4 = 1'b0;
        @(posedge clk); #1;
        check("mulign e1 done", done_4, 0);
        @(negedge clk);
        ld_4 = 1'b1; s_4 = 3'd0; in1_4 = 4'd1; in2_4 = 4'd1;
        @(posedge clk); #1;
        ld_4 = 1'b0;
        check("mulign e2 busy", busy_4, 1);
        check("mulign e2 done", done_4, 0);
        @(posedge clk); #1;
        check("mulign e3 done", done_4, 0);
        check("mulign e3 out_hold", out_4, tbl[22].out);
        @(posedge clk); #1;
        check("mulign e4 done", done_4, 1);
        check("mulign e4 out", out_4, 8'hE1);
        check("mulign e4 cout", cout_4, 1);
        check("mulign e4 busy", busy_4, 0);
        repeat (2) begin
            @(posedge clk); #1;
            check("mulign no_queue done", done_4, 0);
            check("mulign no_queue busy", busy_4, 0);
        end

        // Up-count 14 -> 2 traced edge by edge.
        exp_cnt[0] = 8'd14; exp_cnt[1] = 8'd15; exp_cnt[2] = 8'd0;
        exp_cnt[3] = 8'd1;  exp_cnt[4] = 8'd2;
        @(negedge clk);
        in1_4 = 4'd14; in2_4 = 4'd2; s_4 = 3'd5; ld_4 = 1'b1;
        @(posedge clk); #1;
        ld_4 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("ucnt e%0d out", k + 1), out_4, exp_cnt[k]);
            check($sformatf("ucnt e%0d done", k + 1), done_4, (k == 4));
            check($sformatf("ucnt e%0d cout", k + 1), cout_4, (k >= 2));
        end

        // Back-to-back: ld held high, next op captured in the done cycle.
        @(negedge clk);
        in1_4 = 4'd1; in2_4 = 4'd2; s_4 = 3'd0; ld_4 = 1'b1;
        @(posedge clk); #1;
        check("b2b capture busy", busy_4, 1);
        @(posedge clk); #1;
        check("b2b first done", done_4, 1);
        check("b2b first out", out_4, 8'h03);
        check("b2b first busy", busy_4, 0);
        in1_4 = 4'd4; in2_4 = 4'd4; s_4 = 3'd1;
        @(posedge clk); #1;
        ld_4 = 1'b0;
        check("b2b second capture done", done_4, 0);
        check("b2b second capture busy", busy_4, 1);
        @(posedge clk); #1;
        check("b2b second done", done_4, 1);
        check("b2b second out", out_4, 8'h00);
        check("b2b second zero", zero_4, 1);
        check("b2b second cout", cout_4, 0);

        // W=8: leave a nonzero result, then reset asynchronously mid-multiply.
        run8(8'hFF, 8'hFF, 3'd0, 1'b0, 0);
        @(negedge clk);
        in1_8 = 8'd200; in2_8 = 8'd100; s_8 = 3'd7; ld_8 = 1'b1;
        @(posedge clk); #1;
        ld_8 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("arst busy", busy_8, 0);
        check("arst done", done_8, 0);
        check("arst out",  out_8,  0);
        check("arst cout", cout_8, 0);
        check("arst zero", zero_8, 0);
        @(negedge clk);
        rst = 1'b1;
        run8(8'd12, 8'd13, 3'd7, 1'b0, 1);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0:       ra = 8'h00;
                1:       ra = 8'hFF;
                default: ra = 8'($urandom);
            endcase
            case ($urandom_range(0, 4))
                0:       rb = 8'h00;
                1:       rb = 8'hFF;
                2:       rb = ra;
                default: rb = 8'($urandom);
            endcase
            rop = 3'($urandom_range(0, 7));
            run8(ra, rb, rop, 1'b1, i + 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
